// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID decoupling queue: entry layout, bubble encoding
// and occupancy classification.
package if_id_queue_pkg;

  localparam int              INSTR_W       = 32;
  localparam int              DEFAULT_DEPTH = 2;
  localparam logic [31:0]     DEFAULT_NOP   = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc_inc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input logic [31:0] cnt, input logic [31:0] depth);
    if (cnt == 32'd0) begin
      return OCC_EMPTY;
    end else if (cnt >= depth) begin
      return OCC_FULL;
    end else begin
      return OCC_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x 64-bit entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally never reset; the parent masks stale data with id_valid.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem_r [DEPTH];

  // Write the pushed entry at the write pointer
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of {pc_inc, instr} between fetch and decode.
// if_ready depends only on registered occupancy, so decode stalls never reach fetch combinationally.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                 DEPTH     = DEFAULT_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [INSTR_W-1:0]       if_pc_inc,
  input  logic [INSTR_W-1:0]       if_instr,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [INSTR_W-1:0]       id_pc_inc,
  output logic [INSTR_W-1:0]       id_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  occ_e          occ_s;
  logic          push_s, pop_s, we_s;
  entry_t        wdata_s, head_s;

  // Occupancy class and the handshakes derived from it
  always_comb begin
    occ_s    = occ_of(32'(count_r), 32'(DEPTH));
    if_ready = (occ_s != OCC_FULL);
    id_valid = (occ_s != OCC_EMPTY);
    push_s   = if_valid & if_ready;
    pop_s    = id_valid & id_ready;
    we_s     = push_s & ~flush;
    wdata_s  = '{pc_inc: if_pc_inc, instr: if_instr};
  end

  // Next pointers/count; flush discards any push or pop in the same cycle
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (flush) begin
      count_nxt_s  = '0;
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_nxt_s  = count_r + CW'(1);
          wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end
        2'b01: begin
          count_nxt_s  = count_r - CW'(1);
          rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end
        2'b11: begin
          wr_ptr_nxt_s = wr_ptr_r + AW'(1);
          rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      count_r  <= count_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  // Head entry to decode, replaced by a bubble when empty
  always_comb begin
    if (id_valid) begin
      id_instr  = head_s.instr;
      id_pc_inc = head_s.pc_inc;
    end else begin
      id_instr  = NOP_INSTR;
      id_pc_inc = 32'h0000_0000;
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH=2): directed vector table plus a
// queue scoreboard that tracks every accepted push and compares the head each cycle.
module tb_if_id_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_pc_inc, if_instr;
  logic        if_ready, id_valid;
  logic [31:0] id_pc_inc, id_instr;
  logic [1:0]  count;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_pc_inc (if_pc_inc),
    .if_instr  (if_instr),
    .if_ready  (if_ready),
    .flush     (flush),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc_inc (id_pc_inc),
    .id_instr  (id_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        id_ready;
    int          exp_count;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic vec_t mk(logic r, logic f, logic v, logic [31:0] pc, logic [31:0] ins,
                              logic rdy, int c, logic ev, logic er, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t t;
    t.rst = r; t.flush = f; t.if_valid = v; t.pc = pc; t.instr = ins; t.id_ready = rdy;
    t.exp_count = c; t.exp_valid = ev; t.exp_ready = er; t.exp_pc = ep; t.exp_instr = ei;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle, update the scoreboard from pre-edge state, then compare after the edge
  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic rdy, input int idx);
    logic do_push, do_pop;
    rst = r; flush = f; if_valid = v; if_pc_inc = pc; if_instr = ins; id_ready = rdy;
    if (r || f) begin
      sbq.delete();
    end else begin
      do_pop  = (sbq.size() != 0) && rdy;
      do_push = v && (sbq.size() < DEPTH);
      if (do_pop) void'(sbq.pop_front());
      if (do_push) sbq.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
    chk("sb_count", idx, 32'(count), 32'(sbq.size()));
    if (sbq.size() != 0) begin
      chk("sb_pc", idx, id_pc_inc, sbq[0][63:32]);
      chk("sb_instr", idx, id_instr, sbq[0][31:0]);
    end else begin
      chk("sb_pc_empty", idx, id_pc_inc, 32'h0000_0000);
      chk("sb_instr_empty", idx, id_instr, NOP);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc_inc = 32'h0; if_instr = 32'h0;

    //          rst   flush v     pc      instr          rdy   cnt valid ready exp_pc  exp_instr
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'd0, 32'h0,        1'b0, 0, 1'b0,1'b1, 32'd0,  NOP));
    // streaming
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd4, 32'h1111_0001,1'b1, 1, 1'b1,1'b1, 32'd4,  32'h1111_0001));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd8, 32'h1111_0002,1'b1, 1, 1'b1,1'b1, 32'd8,  32'h1111_0002));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd12,32'h1111_0003,1'b1, 1, 1'b1,1'b1, 32'd12, 32'h1111_0003));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));
    // fill, refused third push, drain
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd16,32'hAAAA_0000,1'b0, 1, 1'b1,1'b1, 32'd16, 32'hAAAA_0000));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd20,32'hBBBB_0000,1'b0, 2, 1'b1,1'b0, 32'd16, 32'hAAAA_0000));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd24,32'hCCCC_0000,1'b0, 2, 1'b1,1'b0, 32'd16, 32'hAAAA_0000));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 1, 1'b1,1'b1, 32'd20, 32'hBBBB_0000));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));
    // flush with simultaneous push and pop
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd28,32'hA2A2_0000,1'b0, 1, 1'b1,1'b1, 32'd28, 32'hA2A2_0000));
    vecs.push_back(mk(1'b0,1'b1,1'b1,32'd32,32'hB2B2_0000,1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));
    // reset mid-operation
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd36,32'hD000_0001,1'b0, 1, 1'b1,1'b1, 32'd36, 32'hD000_0001));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd40,32'hD000_0002,1'b0, 2, 1'b1,1'b0, 32'd36, 32'hD000_0001));
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'd44,32'hD000_0003,1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));
    // full boundary with simultaneous pop
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd48,32'hE000_0001,1'b0, 1, 1'b1,1'b1, 32'd48, 32'hE000_0001));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd52,32'hE000_0002,1'b0, 2, 1'b1,1'b0, 32'd48, 32'hE000_0001));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd56,32'hE000_0003,1'b1, 1, 1'b1,1'b1, 32'd52, 32'hE000_0002));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'd56,32'hE000_0003,1'b0, 2, 1'b1,1'b0, 32'd52, 32'hE000_0002));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 1, 1'b1,1'b1, 32'd56, 32'hE000_0003));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'd0, 32'h0,        1'b1, 0, 1'b0,1'b1, 32'd0,  NOP));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].if_valid, vecs[i].pc, vecs[i].instr,
           vecs[i].id_ready, i);
      chk("count", i, 32'(count), 32'(vecs[i].exp_count));
      chk("id_valid", i, 32'(id_valid), 32'(vecs[i].exp_valid));
      chk("if_ready", i, 32'(if_ready), 32'(vecs[i].exp_ready));
      chk("id_pc_inc", i, id_pc_inc, vecs[i].exp_pc);
      chk("id_instr", i, id_instr, vecs[i].exp_instr);
    end

    // Wrap-around: alternate push and pop so both pointers cross the end repeatedly
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        step(1'b0, 1'b0, 1'b1, 32'd100 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 1'b0, 100 + k);
        chk("wrap_instr", 100 + k, id_instr, 32'hC0DE_0000 + 32'(k));
      end else begin
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h0, 1'b1, 100 + k);
        chk("wrap_empty", 100 + k, 32'(id_valid), 32'd0);
      end
    end

    // Sustained streaming with both ends active after the wrap
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'd200 + 32'(4 * k), 32'h5EED_0000 + 32'(k), 1'b1, 200 + k);
      chk("stream_count", 200 + k, 32'(count), 32'd1);
      chk("stream_pc", 200 + k, id_pc_inc, 32'd200 + 32'(4 * k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
